// File: rtl/stopwatch_pkg.sv
// Shared definitions for the BCD stopwatch: controller states, digit count
// and the active-low 7-segment patterns ({g..a}).
package stopwatch_pkg;

    localparam int NDIG = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low one-hot anode enable for a 2-bit digit select.
    function automatic logic [3:0] digitEnable(input logic [1:0] sel);
        return ~(4'b0001 << sel);
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD to active-low 7-segment decoder; non-BCD codes blank
// the digit.
module seg7_decoder
    import stopwatch_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/stopwatch_bcd_display.sv
// 4-digit BCD stopwatch counting rising edges of a divided clock (sampled as
// data), with start/stop/clear control and a multiplexed active-low display.
module stopwatch_bcd_display
    import stopwatch_pkg::*;
#(
    parameter int SCAN_W = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clk_div,
    input  logic        i_start_stop,
    input  logic        i_clear,
    output logic        o_running,
    output logic [15:0] o_bcd,
    output logic        o_overflow,
    output logic [3:0]  o_an,
    output logic [6:0]  o_seg,
    output logic        o_dp
);

    state_t              r_state;
    state_t              w_nextState;
    logic                r_running;
    logic [15:0]         r_bcd;
    logic                r_overflow;
    logic                r_clkDivQ;
    logic                w_tick;
    logic [15:0]         w_bcdInc;
    logic                w_carry;

    logic [SCAN_W-1:0]   r_scanCnt;
    logic [1:0]          w_sel;
    logic [3:0]          w_digit;
    logic [6:0]          w_segDecoded;
    logic [3:0]          r_an;
    logic [6:0]          r_seg;
    logic                r_dp;

    assign w_tick = i_clk_div & ~r_clkDivQ;

    always_comb begin
        w_nextState = r_state;
        if (i_clear) begin
            w_nextState = IDLE;
        end else if (i_start_stop) begin
            case (r_state)
                IDLE:    w_nextState = RUN;
                RUN:     w_nextState = STOP;
                STOP:    w_nextState = RUN;
                default: w_nextState = IDLE;
            endcase
        end
    end

    // Carry ripples through every digit in one cycle; w_carry out means 9999 wrapped.
    always_comb begin
        w_bcdInc = r_bcd;
        w_carry  = 1'b1;
        for (int d = 0; d < NDIG; d++) begin
            if (w_carry) begin
                if (r_bcd[d*4 +: 4] == 4'd9) begin
                    w_bcdInc[d*4 +: 4] = 4'd0;
                end else begin
                    w_bcdInc[d*4 +: 4] = r_bcd[d*4 +: 4] + 4'd1;
                    w_carry            = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_running  <= 1'b0;
            r_bcd      <= '0;
            r_overflow <= 1'b0;
            r_clkDivQ  <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_running <= (w_nextState == RUN);
            r_clkDivQ <= i_clk_div;
            if (i_clear) begin
                r_bcd      <= '0;
                r_overflow <= 1'b0;
            end else if (w_tick && (r_state == RUN)) begin
                r_bcd <= w_bcdInc;
                if (w_carry) begin
                    r_overflow <= 1'b1;
                end
            end
        end
    end

    assign w_sel   = r_scanCnt[SCAN_W-1 -: 2];
    assign w_digit = r_bcd[{w_sel, 2'b00} +: 4];

    seg7_decoder u_decoder (
        .i_bcd (w_digit),
        .o_seg (w_segDecoded)
    );

    // Decimal point sits after the hundreds digit, giving an XX.XX readout.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_scanCnt <= '0;
            r_an      <= 4'b1111;
            r_seg     <= SEG_BLANK;
            r_dp      <= 1'b1;
        end else begin
            r_scanCnt <= r_scanCnt + 1'b1;
            r_an      <= digitEnable(w_sel);
            r_seg     <= w_segDecoded;
            r_dp      <= (w_sel != 2'd2);
        end
    end

    assign o_running  = r_running;
    assign o_bcd      = r_bcd;
    assign o_overflow = r_overflow;
    assign o_an       = r_an;
    assign o_seg      = r_seg;
    assign o_dp       = r_dp;

endmodule

// File: tb/tb_stopwatch_bcd_display.sv
// Scoreboard bench: stimulus pushes expectations from an integer-arithmetic
// stopwatch model; a negedge monitor pops and compares against the DUT.
module tb_stopwatch_bcd_display;

    localparam int SCAN_W = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        clkDiv = 1'b0;
    logic        startStop = 1'b0;
    logic        clear = 1'b0;
    logic        running;
    logic [15:0] bcd;
    logic        overflow;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    always #5 clock = ~clock;

    stopwatch_bcd_display #(.SCAN_W(SCAN_W)) dut (
        .i_clk        (clock),
        .i_rst        (reset),
        .i_clk_div    (clkDiv),
        .i_start_stop (startStop),
        .i_clear      (clear),
        .o_running    (running),
        .o_bcd        (bcd),
        .o_overflow   (overflow),
        .o_an         (an),
        .o_seg        (seg),
        .o_dp         (dp)
    );

    typedef struct {
        bit [8*16-1:0] tag;
        logic [15:0]   bcd;
        logic          running;
        logic          overflow;
        logic          chkDisp;
        logic [3:0]    an;
        logic [6:0]    seg;
        logic          dp;
    } exp_t;

    exp_t expQ[$];
    exp_t monEntry;
    int   compared   = 0;
    int   mismatched = 0;

    logic [6:0] segTab [0:9];

    // Reference model: count as a plain integer, mode 0=idle 1=run 2=stop.
    int   mCount   = 0;
    int   mMode    = 0;
    bit   mOvf     = 0;
    bit   mPrevDiv = 0;
    int   mScan    = 0;
    logic [3:0] mAn  = 4'hF;
    logic [6:0] mSeg = 7'h7F;
    logic       mDp  = 1'b1;

    function automatic logic [15:0] toBcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic int digitOf(input int v, input int pos);
        int p = 1;
        for (int k = 0; k < pos; k++) p = p * 10;
        return (v / p) % 10;
    endfunction

    function automatic void modelStep(input bit div, input bit ss, input bit clr, input bit rst);
        int sel;
        bit tick;
        if (rst) begin
            mCount = 0; mMode = 0; mOvf = 0; mPrevDiv = 0; mScan = 0;
            mAn = 4'hF; mSeg = 7'h7F; mDp = 1'b1;
            return;
        end
        sel  = mScan / 4;
        mAn  = 4'hF & ~(4'h1 << sel);
        mSeg = segTab[digitOf(mCount, sel)];
        mDp  = (sel == 2) ? 1'b0 : 1'b1;
        mScan = (mScan + 1) % 16;
        tick = div && !mPrevDiv;
        if (clr) begin
            mCount = 0; mOvf = 0; mMode = 0;
        end else begin
            if (tick && mMode == 1) begin
                mCount = mCount + 1;
                if (mCount == 10000) begin
                    mCount = 0;
                    mOvf   = 1;
                end
            end
            if (ss) mMode = (mMode == 1) ? 2 : 1;
        end
        mPrevDiv = div;
    endfunction

    task automatic checkOutput(input exp_t e);
        bit ok;
        ok = (bcd === e.bcd) && (running === e.running) && (overflow === e.overflow);
        if (e.chkDisp) ok = ok && (an === e.an) && (seg === e.seg) && (dp === e.dp);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("[TB] FAIL %0s @%0t: got bcd=%h run=%b ovf=%b an=%b seg=%b dp=%b, expected bcd=%h run=%b ovf=%b an=%b seg=%b dp=%b (disp checked=%b)",
                     e.tag, $time, bcd, running, overflow, an, seg, dp,
                     e.bcd, e.running, e.overflow, e.an, e.seg, e.dp, e.chkDisp);
        end
    endtask

    always begin
        @(negedge clock);
        while (expQ.size() > 0) begin
            monEntry = expQ.pop_front();
            checkOutput(monEntry);
        end
    end

    task automatic applyStimulus(input bit div, input bit ss, input bit clr, input bit rst);
        exp_t e;
        clkDiv    = div;
        startStop = ss;
        clear     = clr;
        reset     = rst;
        @(posedge clock);
        modelStep(div, ss, clr, rst);
        #1;
        e.tag      = "cycle";
        e.bcd      = toBcd(mCount);
        e.running  = (mMode == 1);
        e.overflow = mOvf;
        e.chkDisp  = 1'b1;
        e.an       = mAn;
        e.seg      = mSeg;
        e.dp       = mDp;
        expQ.push_back(e);
    endtask

    task automatic checkpoint(input bit [8*16-1:0] tag, input logic [15:0] eBcd,
                              input logic eRun, input logic eOvf);
        exp_t e;
        e.tag      = tag;
        e.bcd      = eBcd;
        e.running  = eRun;
        e.overflow = eOvf;
        e.chkDisp  = 1'b0;
        e.an       = 4'hF;
        e.seg      = 7'h7F;
        e.dp       = 1'b1;
        expQ.push_back(e);
    endtask

    task automatic pulseEdge(input int hi, input int lo);
        repeat (hi) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (lo) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic randEdges(input int n);
        for (int i = 0; i < n; i++) pulseEdge($urandom_range(1, 2), $urandom_range(1, 2));
    endtask

    initial begin
        bit d;
        segTab[0] = 7'b1000000; segTab[1] = 7'b1111001; segTab[2] = 7'b0100100;
        segTab[3] = 7'b0110000; segTab[4] = 7'b0011001; segTab[5] = 7'b0010010;
        segTab[6] = 7'b0000010; segTab[7] = 7'b1111000; segTab[8] = 7'b0000000;
        segTab[9] = 7'b0010000;

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkpoint("reset", 16'h0000, 1'b0, 1'b0);
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (12) pulseEdge(5, 5);
        checkpoint("count12", 16'h0012, 1'b1, 1'b0);

        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (3) pulseEdge(5, 5);
        checkpoint("paused", 16'h0012, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        pulseEdge(5, 5);
        checkpoint("resumed", 16'h0013, 1'b1, 1'b0);
        pulseEdge(50, 5);
        checkpoint("longHigh", 16'h0014, 1'b1, 1'b0);

        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checkpoint("clrBeatsSs", 16'h0000, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkpoint("ssTickIdle", 16'h0000, 1'b1, 1'b0);
        repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkpoint("ssTickRun", 16'h0001, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        randEdges(9999);
        checkpoint("at9999", 16'h9999, 1'b1, 1'b0);
        pulseEdge(2, 2);
        checkpoint("wrap", 16'h0000, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkpoint("clrAfterWrap", 16'h0000, 1'b0, 1'b0);

        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        randEdges(1234);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkpoint("at1234", 16'h1234, 1'b0, 1'b0);
        repeat (20) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

        d = 1'b0;
        repeat (400) begin
            if ($urandom_range(0, 2) == 0) d = ~d;
            applyStimulus(d, $urandom_range(0, 11) == 0, $urandom_range(0, 49) == 0,
                          $urandom_range(0, 199) == 0);
        end

        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        randEdges(5);
        checkpoint("run5", 16'h0005, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        checkpoint("midReset", 16'h0000, 1'b0, 1'b0);
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 10 && expQ.size() > 0; i++) @(posedge clock);
        if (expQ.size() > 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL drain: %0d expectations left, required 0", expQ.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
